countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter NBITS, default 5, SHALL set the width of load_value and counter.
REQ-002 Parameter DEFAULT_LOAD, default 5'b11000, SHALL be the value captured on start when load_value is all zeros and AUTO_RELOAD_EN is defined.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 enable  input  1  SHALL be the count tick; decrements occur only in cycles where it is 1.
REQ-006 start  input  1  SHALL request a load of load_value and a countdown.
REQ-007 stop  input  1  SHALL abort a running countdown.
REQ-008 load_value  input  NBITS  SHALL be the start value, sampled only on an accepted start.
REQ-009 busy  output  1  SHALL be 1 exactly while the FSM is in RUN.
REQ-010 done  output  1  SHALL be a one-cycle pulse, 1 exactly while the FSM is in DONE.
REQ-011 counter  output  NBITS  SHALL present the current count register.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE; all outputs SHALL be registered or decoded from state only.
REQ-013 Transitions from IDLE:
- start=1 and load_value!=0: go to RUN and set counter=load_value at the same edge.
- start=1 and load_value==0: go to DONE with counter=0.
REQ-014 In RUN with enable=1 and counter>1, counter SHALL decrement by 1 at the edge.
REQ-015 In RUN with enable=1 and counter==1, counter SHALL become 0 and the FSM SHALL enter DONE at the same edge.
REQ-016 In RUN with enable=0, counter and state SHALL hold.
REQ-017 In RUN, stop=1 SHALL return to IDLE with counter held and no done pulse.
REQ-018 stop SHALL take priority over start and enable in the same cycle.
REQ-019 In RUN, start=1 with stop=0 SHALL restart: counter=load_value, remain in RUN; a zero load_value SHALL go to DONE. Enable is ignored in that cycle.
REQ-020 DONE SHALL last exactly one cycle and then go to IDLE. start, stop and enable SHALL be ignored in DONE.
REQ-021 In IDLE, counter SHALL hold its last value; enable alone SHALL have no effect.
REQ-022 Counter arithmetic SHALL be unsigned NBITS and SHALL never wrap below 0.

Reset
REQ-023 While reset=1, state SHALL be IDLE, counter SHALL be 0, and busy and done SHALL be 0, independent of clk.
REQ-024 Reset asserted mid-RUN or mid-DONE SHALL abort immediately with no done pulse.
REQ-025 Operation SHALL resume on the first rising edge after reset falls.

Configuration
REQ-026 Macro COUNTDOWN_AUTO_RELOAD_EN defined:
- DONE SHALL go to RUN with counter reloaded from the value captured at the last accepted start, with done still pulsing for one cycle.
- stop in DONE SHALL go to IDLE.
- A captured value of 0 SHALL be replaced by DEFAULT_LOAD.
REQ-027 Macro undefined: DONE SHALL always go to IDLE and no capture register SHALL exist.

Structure
REQ-028 Package countdown_timer_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default NBITS and DEFAULT_LOAD constants.
REQ-029 Sub-module down_counter SHALL hold the count register with load, decrement and zero-detect; countdown_timer SHALL contain the FSM.

Verification
REQ-030 Scenario: reset pulse mid-count -> counter=0, busy=0, done=0 asynchronously.
REQ-031 Scenario: start with load_value=3, enable held 1 -> counter 3,2,1,0; done=1 for the single cycle after counter reaches 0; busy=0 afterwards.
REQ-032 Scenario: load_value=5, enable toggling 1,0,1,0 -> counter decrements only on enable cycles: 5,4,4,3,3.
REQ-033 Scenario: load_value=4, stop asserted at counter=2 -> IDLE, counter holds 2, no done. Then start with stop high simultaneously -> stays IDLE.
REQ-034 Scenario: start with load_value=0 -> done pulse on the next cycle, busy never 1. A start at counter=2 with load_value=7 -> counter=7.
REQ-035 Scenario: with COUNTDOWN_AUTO_RELOAD_EN, load_value=2 -> counter 2,1,0,2,1,0 with a done pulse at each 0; stop exits to IDLE.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared state encoding and default sizing for the countdown timer.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int                  DEF_NBITS = 5;
  localparam logic [DEF_NBITS-1:0] DEF_LOAD = 5'b11000;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with zero/one detect; load wins over decrement, saturates at 0.
// Single-edge update; no backpressure, the controller decides when to load or count.
module down_counter
  import countdown_timer_pkg::*;
#(
  parameter int NBITS = DEF_NBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [NBITS-1:0] load_val,
  input  logic             dec,
  output logic [NBITS-1:0] count,
  output logic             is_zero,
  output logic             is_one
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign is_zero = (count == '0);
  assign is_one  = (count == NBITS'(1));

endmodule

// File: rtl/countdown_timer.sv
// Countdown FSM (IDLE/RUN/DONE) over down_counter; state and count update one edge after inputs, no backpressure.
// Optional COUNTDOWN_AUTO_RELOAD_EN: DONE re-enters RUN from the value captured at the last accepted start.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int               NBITS        = DEF_NBITS,
  parameter logic [NBITS-1:0] DEFAULT_LOAD = NBITS'(DEF_LOAD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic [NBITS-1:0] load_value,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] counter
);

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             dec;
  logic [NBITS-1:0] load_val;
  logic             is_zero;
  logic             is_one;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [NBITS-1:0] captured;
  logic [NBITS-1:0] reload_val;

  // Any load outside DONE is an accepted start; DONE loads come from this register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      captured <= '0;
    end else if (load && (state != DONE)) begin
      captured <= load_value;
    end
  end

  assign reload_val = (captured == '0) ? DEFAULT_LOAD : captured;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    dec       = 1'b0;
    load_val  = load_value;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          load      = 1'b1;
          state_nxt = (load_value == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (start) begin
          load      = 1'b1;
          state_nxt = (load_value == '0) ? DONE : RUN;
        end else if (enable) begin
          dec = 1'b1;
          if (is_one || is_zero) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (stop) begin
          state_nxt = IDLE;
        end else begin
          load      = 1'b1;
          load_val  = reload_val;
          state_nxt = RUN;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  down_counter #(
    .NBITS(NBITS)
  ) u_down_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .load_val(load_val),
    .dec     (dec),
    .count   (counter),
    .is_zero (is_zero),
    .is_one  (is_one)
  );

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: per-cycle expected {counter,busy,done} go through a scoreboard queue.
module tb_countdown_timer;

  typedef struct packed {
    logic [4:0] cnt;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct packed {
    logic       st;
    logic       sp;
    logic       en;
    logic [4:0] lv;
    logic [4:0] cnt;
    logic       busy;
    logic       done;
  } row_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [4:0] load_value = '0;
  logic       busy;
  logic       done;
  logic [4:0] counter;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  countdown_timer dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .start     (start),
    .stop      (stop),
    .load_value(load_value),
    .busy      (busy),
    .done      (done),
    .counter   (counter)
  );

  always #5 clk = ~clk;

  function automatic row_t r(input logic st, input logic sp, input logic en, input int lv,
                             input int c, input logic b, input logic d);
    row_t x;
    x.st = st; x.sp = sp; x.en = en; x.lv = 5'(lv);
    x.cnt = 5'(c); x.busy = b; x.done = d;
    return x;
  endfunction

  // Drive one cycle of inputs, record what must be visible after the edge.
  task automatic apply(input row_t rw);
    @(negedge clk);
    start = rw.st; stop = rw.sp; enable = rw.en; load_value = rw.lv;
    sb.push_back(exp_t'{rw.cnt, rw.busy, rw.done});
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b0; stop = 1'b0; enable = 1'b0; load_value = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    start = 1'b1; enable = 1'b1; load_value = 5'd5;
    #3;
    sb.push_back(exp_t'{5'd0, 1'b0, 1'b0});
    e = sb.pop_front();
    total++;
    if ({counter, busy, done} !== e) begin
      bad++;
      $display("FAIL reset_initial: got cnt=%0d busy=%b done=%b, want cnt=%0d busy=%b done=%b",
               counter, busy, done, e.cnt, e.busy, e.done);
    end
    @(posedge clk); #1;
    sb.push_back(exp_t'{5'd0, 1'b0, 1'b0});
    e = sb.pop_front();
    total++;
    if ({counter, busy, done} !== e) begin
      bad++;
      $display("FAIL reset_held: got cnt=%0d busy=%b done=%b, want cnt=%0d busy=%b done=%b",
               counter, busy, done, e.cnt, e.busy, e.done);
    end
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
  endtask

  task automatic test_countdown();
    row_t tbl[$];
    exp_t e;
    tbl.push_back(r(1, 0, 1, 3, 3, 1, 0));
    tbl.push_back(r(0, 0, 1, 0, 2, 1, 0));
    tbl.push_back(r(0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(r(0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(r(0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(r(0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      e = sb.pop_front();
      total++;
      if ({counter, busy, done} !== e) begin
        bad++;
        $display("FAIL countdown[%0d]: got cnt=%0d busy=%b done=%b, want cnt=%0d busy=%b done=%b",
                 i, counter, busy, done, e.cnt, e.busy, e.done);
      end
    end
  endtask

  task automatic test_enable_gating();
    row_t tbl[$];
    exp_t e;
    tbl.push_back(r(1, 0, 0, 5, 5, 1, 0));
    tbl.push_back(r(0, 0, 1, 0, 4, 1, 0));
    tbl.push_back(r(0, 0, 0, 0, 4, 1, 0));
    tbl.push_back(r(0, 0, 1, 0, 3, 1, 0));
    tbl.push_back(r(0, 0, 0, 0, 3, 1, 0));
    tbl.push_back(r(0, 1, 0, 0, 3, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      e = sb.pop_front();
      total++;
      if ({counter, busy, done} !== e) begin
        bad++;
        $display("FAIL enable_gating[%0d]: got cnt=%0d busy=%b done=%b, want cnt=%0d busy=%b done=%b",
                 i, counter, busy, done, e.cnt, e.busy, e.done);
      end
    end
  endtask

  task automatic test_stop();
    row_t tbl[$];
    exp_t e;
    tbl.push_back(r(1, 0, 0, 4, 4, 1, 0));
    tbl.push_back(r(0, 0, 1, 0, 3, 1, 0));
    tbl.push_back(r(0, 0, 1, 0, 2, 1, 0));
    tbl.push_back(r(1, 1, 1, 9, 2, 0, 0));
    tbl.push_back(r(1, 1, 1, 9, 2, 0, 0));
    tbl.push_back(r(0, 0, 1, 0, 2, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      e = sb.pop_front();
      total++;
      if ({counter, busy, done} !== e) begin
        bad++;
        $display("FAIL stop[%0d]: got cnt=%0d busy=%b done=%b, want cnt=%0d busy=%b done=%b",
                 i, counter, busy, done, e.cnt, e.busy, e.done);
      end
    end
  endtask

  task automatic test_zero_load_restart();
    row_t tbl[$];
    exp_t e;
    tbl.push_back(r(1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(r(0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(r(1, 0, 0, 4, 4, 1, 0));
    tbl.push_back(r(0, 0, 1, 0, 3, 1, 0));
    tbl.push_back(r(0, 0, 1, 0, 2, 1, 0));
    tbl.push_back(r(1, 0, 1, 7, 7, 1, 0));
    tbl.push_back(r(0, 0, 1, 0, 6, 1, 0));
    tbl.push_back(r(1, 0, 1, 0, 0, 0, 1));
    tbl.push_back(r(1, 1, 1, 5, 0, 0, 0));
    tbl.push_back(r(0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      e = sb.pop_front();
      total++;
      if ({counter, busy, done} !== e) begin
        bad++;
        $display("FAIL zero_restart[%0d]: got cnt=%0d busy=%b done=%b, want cnt=%0d busy=%b done=%b",
                 i, counter, busy, done, e.cnt, e.busy, e.done);
      end
    end
  endtask

  task automatic test_reset_mid();
    row_t tbl[$];
    exp_t e;
    tbl.push_back(r(1, 0, 0, 6, 6, 1, 0));
    tbl.push_back(r(0, 0, 1, 0, 5, 1, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      e = sb.pop_front();
      total++;
      if ({counter, busy, done} !== e) begin
        bad++;
        $display("FAIL reset_mid_pre[%0d]: got cnt=%0d busy=%b done=%b, want cnt=%0d busy=%b done=%b",
                 i, counter, busy, done, e.cnt, e.busy, e.done);
      end
    end
    // Assert reset between edges: outputs must clear without a clock edge.
    @(negedge clk); #2;
    reset = 1'b1;
    sb.push_back(exp_t'{5'd0, 1'b0, 1'b0});
    #1;
    e = sb.pop_front();
    total++;
    if ({counter, busy, done} !== e) begin
      bad++;
      $display("FAIL reset_mid_run: got cnt=%0d busy=%b done=%b, want cnt=%0d busy=%b done=%b",
               counter, busy, done, e.cnt, e.busy, e.done);
    end
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    tbl.delete();
    tbl.push_back(r(1, 0, 0, 2, 2, 1, 0));
    tbl.push_back(r(1, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      e = sb.pop_front();
      total++;
      if ({counter, busy, done} !== e) begin
        bad++;
        $display("FAIL reset_resume[%0d]: got cnt=%0d busy=%b done=%b, want cnt=%0d busy=%b done=%b",
                 i, counter, busy, done, e.cnt, e.busy, e.done);
      end
    end
    #1;
    clear_inputs();
    reset = 1'b1;
    sb.push_back(exp_t'{5'd0, 1'b0, 1'b0});
    #1;
    e = sb.pop_front();
    total++;
    if ({counter, busy, done} !== e) begin
      bad++;
      $display("FAIL reset_mid_done: got cnt=%0d busy=%b done=%b, want cnt=%0d busy=%b done=%b",
               counter, busy, done, e.cnt, e.busy, e.done);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    row_t tbl[$];
    exp_t e;
    tbl.push_back(r(1, 0, 0, 1, 1, 1, 0));
    tbl.push_back(r(0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(r(0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(r(1, 0, 1, 2, 0, 0, 0));
    tbl.push_back(r(1, 0, 0, 31, 31, 1, 0));
    tbl.push_back(r(0, 0, 1, 0, 30, 1, 0));
    tbl.push_back(r(0, 1, 0, 0, 30, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      e = sb.pop_front();
      total++;
      if ({counter, busy, done} !== e) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got cnt=%0d busy=%b done=%b, want cnt=%0d busy=%b done=%b",
                 i, counter, busy, done, e.cnt, e.busy, e.done);
      end
    end
  endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    row_t tbl[$];
    exp_t e;
    tbl.push_back(r(1, 0, 1, 2, 2, 1, 0));
    tbl.push_back(r(0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(r(0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(r(0, 0, 1, 0, 2, 1, 0));
    tbl.push_back(r(0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(r(0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(r(0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(r(1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(r(0, 0, 0, 0, 24, 1, 0));
    tbl.push_back(r(0, 1, 0, 0, 24, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      e = sb.pop_front();
      total++;
      if ({counter, busy, done} !== e) begin
        bad++;
        $display("FAIL auto_reload[%0d]: got cnt=%0d busy=%b done=%b, want cnt=%0d busy=%b done=%b",
                 i, counter, busy, done, e.cnt, e.busy, e.done);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    test_auto_reload();
`else
    test_countdown();
    test_enable_gating();
    test_stop();
    test_zero_load_restart();
    test_reset_mid();
    test_back_to_back();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
